// File: rtl/bus_b_split_arbiter.sv
// ---------------------------------------------------------------------------
// bus_b_split_arbiter
// Purpose: grants bus B to two initiators (0 = bridge initiator, 1 = local
// bus-B initiator) with round-robin fairness. One split transaction can be
// parked at a time. The split target gives the bus up with i_split_ack and
// later takes it back with i_split_req to return data to the parked
// initiator. A watchdog revokes a grant that is held too long.
//
// Ports:
//   i_clk            clock, rising edge
//   i_rst            asynchronous active-high reset
//   i_req[1:0]       per-initiator request level
//   i_txn_done       pulse: current bus transaction finished
//   i_split_ack      pulse: addressed target splits the current transaction
//   i_split_req      level: split target ready to return parked data
//   o_grant[1:0]     one-hot (or zero) initiator grant, registered
//   o_split_grant    bus granted to the split target for data return
//   o_owner_id       initiator currently granted (split owner in return)
//   o_bus_busy       high while OWNED or SPLIT_RETURN
//   o_split_pending  a split transaction is parked
//   o_timeout_pulse  pulse: watchdog revoked a grant
//   o_split_overflow pulse: split_ack while a split was already parked
// ---------------------------------------------------------------------------
module bus_b_split_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_txn_done,
  input  logic       i_split_ack,
  input  logic       i_split_req,
  output logic [1:0] o_grant,
  output logic       o_split_grant,
  output logic       o_owner_id,
  output logic       o_bus_busy,
  output logic       o_split_pending,
  output logic       o_timeout_pulse,
  output logic       o_split_overflow
);

  // A zero timeout would give a zero-width counter; keep at least one bit.
  localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_OWNED        = 2'd1,
    ST_SPLIT_RETURN = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_owner;
  logic          r_last_owner;
  logic          r_split_owner;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_grant;
  logic          r_split_grant;
  logic          r_owner_id;
  logic          r_bus_busy;
  logic          r_split_pending;
  logic          r_timeout_pulse;
  logic          r_split_overflow;

  logic [1:0]    w_elig;
  logic          w_pick;
  logic [CW-1:0] w_cnt_inc;
  logic          w_timeout;
  logic          w_owned_exit;

  // The parked initiator is never re-granted until its data has returned.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_elig
      assign w_elig[gi] = i_req[gi] && !(r_split_pending && (r_split_owner == 1'(gi)));
    end
  endgenerate

  // On a tie, the initiator that did not own the bus last time wins.
  assign w_pick = (w_elig == 2'b11) ? ~r_last_owner : w_elig[1];

  assign w_cnt_inc = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);
  // The count after this edge reaching the limit means the grant has been
  // high for exactly TIMEOUT_CYCLES cycles when it drops.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_inc >= TO_VAL);

  assign w_owned_exit = i_split_ack || i_txn_done || !i_req[r_owner] || w_timeout;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state          <= ST_IDLE;
      r_owner          <= 1'b0;
      r_last_owner     <= 1'b1;
      r_split_owner    <= 1'b0;
      r_cnt            <= '0;
      r_grant          <= 2'b00;
      r_split_grant    <= 1'b0;
      r_owner_id       <= 1'b0;
      r_bus_busy       <= 1'b0;
      r_split_pending  <= 1'b0;
      r_timeout_pulse  <= 1'b0;
      r_split_overflow <= 1'b0;
    end else begin
      r_timeout_pulse  <= 1'b0;
      r_split_overflow <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (r_split_pending && i_split_req) begin
            r_state       <= ST_SPLIT_RETURN;
            r_grant       <= {r_split_owner, ~r_split_owner};
            r_split_grant <= 1'b1;
            r_owner_id    <= r_split_owner;
            r_bus_busy    <= 1'b1;
          end else if (|w_elig) begin
            r_state    <= ST_OWNED;
            r_owner    <= w_pick;
            r_grant    <= {w_pick, ~w_pick};
            r_owner_id <= w_pick;
            r_bus_busy <= 1'b1;
          end
        end

        ST_OWNED: begin
          r_cnt <= w_cnt_inc;
          if (w_owned_exit) begin
            r_state      <= ST_IDLE;
            r_grant      <= 2'b00;
            r_owner_id   <= 1'b0;
            r_bus_busy   <= 1'b0;
            r_cnt        <= '0;
            r_last_owner <= r_owner;
            if (i_split_ack) begin
              // Only one split can be parked; a second one ends as if done.
              if (!r_split_pending) begin
                r_split_pending <= 1'b1;
                r_split_owner   <= r_owner;
              end else begin
                r_split_overflow <= 1'b1;
              end
            end else if (!i_txn_done && i_req[r_owner]) begin
              // Nothing else ended the transaction: watchdog revocation.
              r_timeout_pulse <= 1'b1;
            end
          end
        end

        ST_SPLIT_RETURN: begin
          r_cnt <= w_cnt_inc;
          // split_req dropping and split_ack are ignored here.
          if (i_txn_done || w_timeout) begin
            r_state         <= ST_IDLE;
            r_grant         <= 2'b00;
            r_split_grant   <= 1'b0;
            r_owner_id      <= 1'b0;
            r_bus_busy      <= 1'b0;
            r_split_pending <= 1'b0;
            r_cnt           <= '0;
            r_last_owner    <= r_split_owner;
            r_timeout_pulse <= !i_txn_done;
          end
        end

        default: begin
          r_state       <= ST_IDLE;
          r_grant       <= 2'b00;
          r_split_grant <= 1'b0;
          r_bus_busy    <= 1'b0;
          r_cnt         <= '0;
        end
      endcase
    end
  end

  assign o_grant          = r_grant;
  assign o_split_grant    = r_split_grant;
  assign o_owner_id       = r_owner_id;
  assign o_bus_busy       = r_bus_busy;
  assign o_split_pending  = r_split_pending;
  assign o_timeout_pulse  = r_timeout_pulse;
  assign o_split_overflow = r_split_overflow;

endmodule

// File: tb/tb_bus_b_split_arbiter.sv
// Scoreboard bench: each stimulus cycle pushes the expected post-edge outputs,
// and a monitor pops and compares them one cycle later. Two instances share
// the stimulus: dut8 (TIMEOUT_CYCLES=8) and dut0 (watchdog disabled); each
// scoreboard entry names which instance it applies to.
module tb_bus_b_split_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req = 2'b00;
  logic       txn_done = 1'b0;
  logic       split_ack = 1'b0;
  logic       split_req = 1'b0;

  logic [1:0] g8, g0;
  logic       sg8, sg0, oid8, oid0, busy8, busy0, pend8, pend0;
  logic       to8, to0, ovf8, ovf0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;
  logic sel_now = 1'b0;

  typedef struct {
    logic       sel;
    logic [1:0] g;
    logic       sg, oid, busy, pend, to, ovf;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  bus_b_split_arbiter #(.TIMEOUT_CYCLES(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_txn_done(txn_done),
    .i_split_ack(split_ack), .i_split_req(split_req),
    .o_grant(g8), .o_split_grant(sg8), .o_owner_id(oid8), .o_bus_busy(busy8),
    .o_split_pending(pend8), .o_timeout_pulse(to8), .o_split_overflow(ovf8)
  );

  bus_b_split_arbiter #(.TIMEOUT_CYCLES(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_txn_done(txn_done),
    .i_split_ack(split_ack), .i_split_req(split_req),
    .o_grant(g0), .o_split_grant(sg0), .o_owner_id(oid0), .o_bus_busy(busy0),
    .o_split_pending(pend0), .o_timeout_pulse(to0), .o_split_overflow(ovf0)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Monitor: compare popped expectations just after the active edge.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [1:0] ag;
      logic asg, aoid, abusy, apend, ato, aovf;
      e = sb_q.pop_front();
      n_txn++;
      if (e.sel) begin
        ag = g0; asg = sg0; aoid = oid0; abusy = busy0; apend = pend0; ato = to0; aovf = ovf0;
      end else begin
        ag = g8; asg = sg8; aoid = oid8; abusy = busy8; apend = pend8; ato = to8; aovf = ovf8;
      end
      $display("txn %0d dut=%s req=%b grant=%b sgrant=%b owner=%b busy=%b pend=%b to=%b ovf=%b",
               n_txn, e.sel ? "t0" : "t8", req, ag, asg, aoid, abusy, apend, ato, aovf);
      chk($sformatf("grant#%0d", n_txn), 32'(ag), 32'(e.g));
      chk($sformatf("split_grant#%0d", n_txn), 32'(asg), 32'(e.sg));
      chk($sformatf("owner_id#%0d", n_txn), 32'(aoid), 32'(e.oid));
      chk($sformatf("bus_busy#%0d", n_txn), 32'(abusy), 32'(e.busy));
      chk($sformatf("split_pending#%0d", n_txn), 32'(apend), 32'(e.pend));
      chk($sformatf("timeout_pulse#%0d", n_txn), 32'(ato), 32'(e.to));
      chk($sformatf("split_overflow#%0d", n_txn), 32'(aovf), 32'(e.ovf));
      chk($sformatf("inv_two_grants#%0d", n_txn), 32'(ag == 2'b11), 32'd0);
      chk($sformatf("inv_sgrant_pend#%0d", n_txn), 32'(asg && !apend), 32'd0);
    end
  end

  // Drive one cycle of stimulus and record the outputs expected after the edge.
  task automatic step(input logic [1:0] r, input logic d, input logic sa, input logic sr,
                      input logic [1:0] g, input logic sg, input logic oid, input logic busy,
                      input logic pend, input logic to, input logic ovf);
    exp_t e;
    @(negedge clk);
    req = r; txn_done = d; split_ack = sa; split_req = sr;
    e.sel = sel_now; e.g = g; e.sg = sg; e.oid = oid; e.busy = busy;
    e.pend = pend; e.to = to; e.ovf = ovf;
    sb_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(g8), 32'd0);
    chk({tag, "_sgrant"}, 32'(sg8), 32'd0);
    chk({tag, "_busy"}, 32'(busy8), 32'd0);
    chk({tag, "_pend"}, 32'(pend8), 32'd0);
    chk({tag, "_owner"}, 32'(oid8), 32'd0);
    chk({tag, "_pulses"}, 32'({to8, ovf8}), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = 2'b00; txn_done = 0; split_ack = 0; split_req = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk_all_zero("reset");

    // 1: round-robin tie, abandoned transaction
    step(2'b11, 0, 0, 0, 2'b01, 0, 0, 1, 0, 0, 0);
    step(2'b11, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    step(2'b11, 0, 0, 0, 2'b10, 0, 1, 1, 0, 0, 0);
    step(2'b11, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    step(2'b01, 0, 0, 0, 2'b01, 0, 0, 1, 0, 0, 0);
    step(2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);

    // 2: split, other initiator served, split return
    do_reset();
    step(2'b01, 0, 0, 0, 2'b01, 0, 0, 1, 0, 0, 0);
    step(2'b11, 0, 1, 0, 2'b00, 0, 0, 0, 1, 0, 0);
    step(2'b11, 0, 0, 0, 2'b10, 0, 1, 1, 1, 0, 0);
    step(2'b11, 1, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0);
    step(2'b11, 0, 0, 1, 2'b01, 1, 0, 1, 1, 0, 0);
    step(2'b11, 0, 0, 0, 2'b01, 1, 0, 1, 1, 0, 0);
    step(2'b11, 0, 1, 0, 2'b01, 1, 0, 1, 1, 0, 0);
    step(2'b11, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    step(2'b11, 0, 0, 0, 2'b10, 0, 1, 1, 0, 0, 0);
    step(2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);

    // 4: second split_ack overflows, parked owner unchanged
    do_reset();
    step(2'b01, 0, 0, 0, 2'b01, 0, 0, 1, 0, 0, 0);
    step(2'b11, 0, 1, 0, 2'b00, 0, 0, 0, 1, 0, 0);
    step(2'b11, 0, 0, 0, 2'b10, 0, 1, 1, 1, 0, 0);
    step(2'b11, 0, 1, 0, 2'b00, 0, 0, 0, 1, 0, 1);
    step(2'b11, 0, 0, 1, 2'b01, 1, 0, 1, 1, 0, 0);
    step(2'b11, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);

    // 3: watchdog fires 8 cycles after grant rises
    do_reset();
    step(2'b01, 0, 0, 0, 2'b01, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(2'b01, 0, 0, 0, 2'b01, 0, 0, 1, 0, 0, 0);
    step(2'b01, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
    step(2'b01, 0, 0, 0, 2'b01, 0, 0, 1, 0, 0, 0);
    step(2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);

    // 5: split_ack wins over txn_done; async reset mid-OWNED
    do_reset();
    step(2'b01, 0, 0, 0, 2'b01, 0, 0, 1, 0, 0, 0);
    step(2'b01, 1, 1, 0, 2'b00, 0, 0, 0, 1, 0, 0);
    step(2'b01, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0);
    step(2'b11, 0, 0, 0, 2'b10, 0, 1, 1, 1, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // 6: split_req without a parked split is ignored; zero timeout never fires
    do_reset();
    step(2'b00, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    step(2'b00, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    sel_now = 1'b1;
    step(2'b01, 0, 0, 0, 2'b01, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(2'b01, 0, 0, 0, 2'b01, 0, 0, 1, 0, 0, 0);
    step(2'b01, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    sel_now = 1'b0;

    @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
